mem_access_stage: RTL



---
 rtl/mem_access_stage.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - handshaked MEM stage: load align/extend, store strobes, misalign and timeout flags
// A fired memory op is latched and replayed on the request port; results are registered toward WB.
module mem_access_stage #(
    parameter int  XLEN    = 32,
    parameter int  TIMEOUT = 255,
    localparam int OFF_W   = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_mem,
    input  logic              in_we,
    input  logic [2:0]        in_rwtype,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic              in_jump,
    input  logic              in_branch,
    input  logic              in_inv_branch,
    input  logic              in_zero,
    input  logic [XLEN-1:0]   in_pc_offset,
    output logic              pc_src,
    output logic [XLEN-1:0]   pc_target,
    output logic              stall,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [XLEN-1:0]   req_addr,
    output logic              req_we,
    output logic [XLEN/8-1:0] req_wstrb,
    output logic [XLEN-1:0]   req_wdata,
    input  logic              resp_valid,
    input  logic [XLEN-1:0]   resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_load_data,
    output logic              out_misaligned,
    output logic              out_bus_err
);
    localparam int STRB_W = XLEN / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [2:0]        type_q, type_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d, mis_q, mis_d, err_q, err_d;
    logic [XLEN-1:0]   data_q, data_d;

    logic              fire, in_mis;
    logic [2:0]        in_type;
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W+2:0]  shamt;
    logic [XLEN-1:0]   shifted, load_ext;
    logic [STRB_W-1:0] strb;

    // Encodings that do not exist at this XLEN collapse to a signed word access.
    function automatic logic [2:0] norm_type(input logic [2:0] t);
        logic [2:0] r;
        r = 3'b010;
        case (t)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: r = t;
            3'b011, 3'b110: if (XLEN == 64) r = t;
            default: r = 3'b010;
        endcase
        return r;
    endfunction

    assign in_type   = norm_type(in_rwtype);
    assign in_ready  = (state_q == S_IDLE) & (~out_valid_q | out_ready);
    assign fire      = in_valid & in_ready;
    assign stall     = in_valid & ~in_ready;
    assign pc_src    = fire & (in_jump | (in_branch & (in_inv_branch ^ in_zero)));
    assign pc_target = in_pc_offset;

    always_comb begin
        in_mis = 1'b0;
        case (in_type[1:0])
            2'd1:    in_mis = in_addr[0];
            2'd2:    in_mis = |in_addr[1:0];
            2'd3:    in_mis = |in_addr[2:0];
            default: in_mis = 1'b0;
        endcase
    end

    assign off_q     = addr_q[OFF_W-1:0];
    assign shamt     = {off_q, 3'b000};
    assign req_valid = (state_q == S_REQ);
    assign req_addr  = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign req_we    = we_q;
    assign req_wdata = wdata_q << shamt;
    assign shifted   = resp_rdata >> shamt;

    always_comb begin
        strb = '1;
        case (type_q[1:0])
            2'd0:    strb = STRB_W'(1) << off_q;
            2'd1:    strb = STRB_W'(3) << off_q;
            2'd2:    strb = STRB_W'(15) << off_q;
            default: strb = '1;
        endcase
    end
    assign req_wstrb = strb;

    always_comb begin
        load_ext = XLEN'($signed(shifted[31:0]));
        case (type_q)
            3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
            3'b100:  load_ext = XLEN'(shifted[7:0]);
            3'b101:  load_ext = XLEN'(shifted[15:0]);
            3'b110:  load_ext = XLEN'(shifted[31:0]);
            3'b011:  load_ext = shifted;
            default: load_ext = XLEN'($signed(shifted[31:0]));
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q & ~out_ready;
        data_d      = data_q;
        mis_d       = mis_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    if (!in_is_mem || in_mis) begin
                        out_valid_d = 1'b1;
                        data_d      = '0;
                        mis_d       = in_is_mem;
                        err_d       = 1'b0;
                    end else begin
                        addr_d  = in_addr;
                        wdata_d = in_wdata;
                        we_d    = in_we;
                        type_d  = in_type;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    if (we_q) begin
                        out_valid_d = 1'b1;
                        data_d      = '0;
                        mis_d       = 1'b0;
                        err_d       = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response arriving on the final counted cycle still beats the timeout.
                if (resp_valid) begin
                    out_valid_d = 1'b1;
                    data_d      = load_ext;
                    mis_d       = 1'b0;
                    err_d       = 1'b0;
                    state_d     = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    out_valid_d = 1'b1;
                    data_d      = '0;
                    mis_d       = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            type_q      <= 3'b010;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            mis_q       <= mis_d;
            err_q       <= err_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_load_data  = data_q;
    assign out_misaligned = mis_q;
    assign out_bus_err    = err_q;
endmodule
